apb_txn_arbiter: RTL and testbench

//  Shares the single APB master between two transaction requesters (r0, r1) and sequences each transfer.

---
 rtl/apb_txn_arbiter.sv | 174 +++++++++++++++++
 tb/tb_apb_txn_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_txn_arbiter.sv
// Purpose: shares one APB master command port between two requesters (round-robin) and sequences each transfer.
// Latency: accept at T, TRANSFER_FLAG from T+1, rsp_valid one cycle after bus completion (illegal select: T+1).
// Backpressure: rN_ready is offered only in IDLE to the arbitration winner; one transfer outstanding at a time.
// Ports:
//   PCLK, PRESETn                        clock, synchronous active-low reset
//   rN_valid/ready/write/addr/wdata/strb/sel  requester N command channel (N = 0, 1)
//   rsp_valid[1:0], rsp_rdata, rsp_err   completion pulse per requester, read data, error status
//   TRANSFER_FLAG, READ1_WRITE0, APB_writeAddress, APB_readAddress, APB_writeData, IN_STRB, Slave_Select
//                                        command outputs to the APB master
//   PENABLE, PREADY, PSLVERR, APB_readData  bus monitor inputs
module apb_txn_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int STRB_WIDTH    = 4,
  parameter int SLAVES_NUM    = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     r0_valid,
  output logic                     r0_ready,
  input  logic                     r0_write,
  input  logic [ADDRESS_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0]    r0_wdata,
  input  logic [STRB_WIDTH-1:0]    r0_strb,
  input  logic [SLAVES_NUM-1:0]    r0_sel,
  input  logic                     r1_valid,
  output logic                     r1_ready,
  input  logic                     r1_write,
  input  logic [ADDRESS_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0]    r1_wdata,
  input  logic [STRB_WIDTH-1:0]    r1_strb,
  input  logic [SLAVES_NUM-1:0]    r1_sel,
  output logic [1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     TRANSFER_FLAG,
  output logic                     READ1_WRITE0,
  output logic [ADDRESS_WIDTH-1:0] APB_writeAddress,
  output logic [ADDRESS_WIDTH-1:0] APB_readAddress,
  output logic [DATA_WIDTH-1:0]    APB_writeData,
  output logic [STRB_WIDTH-1:0]    IN_STRB,
  output logic [SLAVES_NUM-1:0]    Slave_Select,
  input  logic                     PENABLE,
  input  logic                     PREADY,
  input  logic                     PSLVERR,
  input  logic [DATA_WIDTH-1:0]    APB_readData
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Keep the counter at least 1 bit wide so TIMEOUT = 0 (disabled) still elaborates.
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TMO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_LIM[CNT_W-1:0];

  logic [1:0]               state;
  logic                     grant;
  logic                     last_grant;
  logic                     lat_write;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]    lat_wdata;
  logic [STRB_WIDTH-1:0]    lat_strb;
  logic [SLAVES_NUM-1:0]    lat_sel;
  logic [CNT_W-1:0]         wait_cnt;

  logic                     idle;
  logic                     busy;
  logic                     win;
  logic                     accept;
  logic                     acc_write;
  logic [ADDRESS_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0]    acc_wdata;
  logic [STRB_WIDTH-1:0]    acc_strb;
  logic [SLAVES_NUM-1:0]    acc_sel;
  logic                     sel_legal;
  logic                     bus_done;
  logic                     timed_out;

  assign idle = (state == ST_IDLE);
  assign busy = (state == ST_ISSUE) || (state == ST_WAIT);

  // With both requesting, the one not served last wins; otherwise whoever asks.
  assign win      = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
  assign r0_ready = idle & r0_valid & ~win;
  assign r1_ready = idle & r1_valid & win;
  assign accept   = r0_ready | r1_ready;

  assign acc_write = win ? r1_write : r0_write;
  assign acc_addr  = win ? r1_addr  : r0_addr;
  assign acc_wdata = win ? r1_wdata : r0_wdata;
  assign acc_strb  = win ? r1_strb  : r0_strb;
  assign acc_sel   = win ? r1_sel   : r0_sel;

  // Exactly one select bit set; 00 and multi-hot are refused without touching the bus.
  assign sel_legal = (acc_sel != '0) && ((acc_sel & (acc_sel - 1'b1)) == '0);

  assign bus_done  = PENABLE & PREADY;
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TMO_LAST);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;  // so r0 wins the first contended arbitration
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_strb   <= '0;
      lat_sel    <= '0;
      wait_cnt   <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            grant     <= win;
            lat_write <= acc_write;
            lat_addr  <= acc_addr;
            lat_wdata <= acc_wdata;
            lat_strb  <= acc_strb;
            lat_sel   <= acc_sel;
            if (sel_legal) begin
              state <= ST_ISSUE;
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= ST_DONE;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion seen on the last allowed WAIT cycle still counts as a completion.
          if (bus_done) begin
            rsp_err   <= PSLVERR;
            rsp_rdata <= lat_write ? '0 : APB_readData;
            state     <= ST_DONE;
          end else if (timed_out) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          last_grant <= grant;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Command outputs are only non-zero while a transfer is on the bus.
  assign TRANSFER_FLAG    = busy;
  assign READ1_WRITE0     = busy & ~lat_write;
  assign APB_writeAddress = (busy &&  lat_write) ? lat_addr : '0;
  assign APB_readAddress  = (busy && !lat_write) ? lat_addr : '0;
  assign APB_writeData    = busy ? lat_wdata : '0;
  assign IN_STRB          = busy ? lat_strb  : '0;
  assign Slave_Select     = busy ? lat_sel   : '0;

  assign rsp_valid = (state == ST_DONE) ? (grant ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_apb_txn_arbiter.sv
// Purpose: self-checking bench for apb_txn_arbiter with request queues, a bus responder and a response scoreboard.
// Latency: responses are matched in order against expectations computed when the request is queued.
// Backpressure: requesters hold valid until the DUT accepts; the responder stalls PREADY per transaction.
module tb_apb_txn_arbiter;

  localparam int TMO = 8;

  logic        PCLK;
  logic        PRESETn;
  logic        r0_valid, r0_ready, r0_write;
  logic [31:0] r0_addr, r0_wdata;
  logic [3:0]  r0_strb;
  logic [1:0]  r0_sel;
  logic        r1_valid, r1_ready, r1_write;
  logic [31:0] r1_addr, r1_wdata;
  logic [3:0]  r1_strb;
  logic [1:0]  r1_sel;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        TRANSFER_FLAG, READ1_WRITE0;
  logic [31:0] APB_writeAddress, APB_readAddress, APB_writeData;
  logic [3:0]  IN_STRB;
  logic [1:0]  Slave_Select;
  logic        PENABLE, PREADY, PSLVERR;
  logic [31:0] APB_readData;

  logic [103:0] cmd_now;
  logic [36:0]  rsp_now;
  assign cmd_now = {TRANSFER_FLAG, READ1_WRITE0, Slave_Select, IN_STRB,
                    APB_writeAddress, APB_readAddress, APB_writeData};
  assign rsp_now = {r0_ready, r1_ready, rsp_valid, rsp_err, rsp_rdata};

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  sel;
    int          ra;        // WAIT cycle on which PREADY rises; 0 = never
    logic [31:0] rd;
    logic        se;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_len;   // cycles TRANSFER_FLAG stays high
    int          exp_lat;   // accept cycle to rsp_valid cycle
  } txn_t;

  txn_t rq0[$];
  txn_t rq1[$];
  txn_t sb[$];

  int n_total  = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int flag_cnt = 0;
  int last_len = 0;

  apb_txn_arbiter #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .STRB_WIDTH(4), .SLAVES_NUM(2), .TIMEOUT(TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_write(r0_write), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_strb(r0_strb), .r0_sel(r0_sel),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_write(r1_write), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_strb(r1_strb), .r1_sel(r1_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .TRANSFER_FLAG(TRANSFER_FLAG), .READ1_WRITE0(READ1_WRITE0),
    .APB_writeAddress(APB_writeAddress), .APB_readAddress(APB_readAddress),
    .APB_writeData(APB_writeData), .IN_STRB(IN_STRB), .Slave_Select(Slave_Select),
    .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .APB_readData(APB_readData)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Expected outcome of one request, from the block's documented behaviour.
  function automatic txn_t make_txn(input int id, input logic wr, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] strb,
                                    input logic [1:0] sel, input int ra,
                                    input logic [31:0] rd, input logic se);
    txn_t t;
    t.id = id; t.wr = wr; t.addr = addr; t.wdata = wdata; t.strb = strb; t.sel = sel;
    t.ra = ra; t.rd = rd; t.se = se;
    if (sel != 2'b01 && sel != 2'b10) begin
      t.exp_err = 1'b1; t.exp_rdata = 32'h0; t.exp_len = 0; t.exp_lat = 1;
    end else if (ra == 0) begin
      t.exp_err = 1'b1; t.exp_rdata = 32'h0; t.exp_len = TMO + 1; t.exp_lat = TMO + 2;
    end else begin
      t.exp_err = se; t.exp_rdata = wr ? 32'h0 : rd; t.exp_len = ra + 1; t.exp_lat = ra + 2;
    end
    return t;
  endfunction

  task automatic submit(input txn_t t);
    if (t.id == 0) rq0.push_back(t);
    else           rq1.push_back(t);
    sb.push_back(t);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || rq0.size() != 0 || rq1.size() != 0) && n < budget) begin
      @(negedge PCLK); #2;
      n++;
    end
    check_eq(tag, sb.size() + rq0.size() + rq1.size(), 0);
    repeat (2) @(negedge PCLK);
    #2;
  endtask

  // Requester drivers, bus responder and response monitor share one loop so their ordering is fixed.
  initial begin : bench_loop
    txn_t t;
    logic acc0, acc1;
    r0_valid = 0; r0_write = 0; r0_addr = 0; r0_wdata = 0; r0_strb = 0; r0_sel = 0;
    r1_valid = 0; r1_write = 0; r1_addr = 0; r1_wdata = 0; r1_strb = 0; r1_sel = 0;
    PENABLE = 0; PREADY = 0; PSLVERR = 0; APB_readData = 0;
    forever begin
      @(negedge PCLK);
      cyc++;
      check_eq("rdy_excl", r0_ready & r1_ready, 0);
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          check_eq("unexp_rsp", rsp_valid, 0);
        end else begin
          t = sb.pop_front();
          check_eq("rsp_valid", rsp_valid, (t.id == 0) ? 2'b01 : 2'b10);
          check_eq("rsp_rdata", rsp_rdata, t.exp_rdata);
          check_eq("rsp_err", rsp_err, t.exp_err);
          check_eq("flag_len", last_len, t.exp_len);
          check_eq("latency", cyc - acc_cyc, t.exp_lat);
          check_eq("done_cmd", cmd_now, 0);
          last_len = 0;
        end
      end
      acc0 = r0_valid & r0_ready;
      acc1 = r1_valid & r1_ready;
      if (acc0 || acc1) acc_cyc = cyc;

      @(posedge PCLK); #1;
      if (acc0 && rq0.size() > 0) void'(rq0.pop_front());
      if (acc1 && rq1.size() > 0) void'(rq1.pop_front());

      // Idle requesters wiggle their fields with valid low; the DUT must ignore them.
      if (rq0.size() > 0) begin
        r0_valid = 1; r0_write = rq0[0].wr; r0_addr = rq0[0].addr;
        r0_wdata = rq0[0].wdata; r0_strb = rq0[0].strb; r0_sel = rq0[0].sel;
      end else begin
        r0_valid = 0; r0_write = 1'($urandom_range(1)); r0_addr = $urandom;
        r0_wdata = $urandom; r0_strb = 4'($urandom); r0_sel = 2'($urandom);
      end
      if (rq1.size() > 0) begin
        r1_valid = 1; r1_write = rq1[0].wr; r1_addr = rq1[0].addr;
        r1_wdata = rq1[0].wdata; r1_strb = rq1[0].strb; r1_sel = rq1[0].sel;
      end else begin
        r1_valid = 0; r1_write = 1'($urandom_range(1)); r1_addr = $urandom;
        r1_wdata = $urandom; r1_strb = 4'($urandom); r1_sel = 2'($urandom);
      end

      if (TRANSFER_FLAG) begin
        flag_cnt++;
      end else begin
        if (flag_cnt != 0) last_len = flag_cnt;
        flag_cnt = 0;
      end
      PENABLE = 0; PREADY = 0; PSLVERR = 0; APB_readData = $urandom;
      if (TRANSFER_FLAG && sb.size() > 0) begin
        t = sb[0];
        check_eq("cmd", cmd_now, {1'b1, ~t.wr, t.sel, t.strb,
                                  t.wr ? t.addr : 32'h0, t.wr ? 32'h0 : t.addr, t.wdata});
        if (flag_cnt >= 2) begin
          PENABLE = 1;
          if (t.ra != 0 && flag_cnt == t.ra + 1) begin
            PREADY = 1; PSLVERR = t.se; APB_readData = t.rd;
          end
        end
      end
    end
  end

  initial begin : main
    int n;
    PRESETn = 0;
    repeat (3) @(negedge PCLK);
    check_eq("rst_cmd", cmd_now, 0);
    check_eq("rst_rsp", rsp_now, 0);
    @(posedge PCLK); #2;
    PRESETn = 1;
    @(negedge PCLK); #2;

    // r0 write to GPIO, PREADY on the second WAIT cycle
    submit(make_txn(0, 1'b1, 32'h0000_0010, 32'h5A5A_0001, 4'hF, 2'b01, 2, 32'h0, 1'b0));
    wait_drain("drain_wr", 40);

    // r1 read from UART; data must hold after the pulse
    submit(make_txn(1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 2'b10, 1, 32'h0000_00C3, 1'b0));
    wait_drain("drain_rd", 40);
    check_eq("hold_rdata", rsp_rdata, 32'h0000_00C3);

    // both requesters busy: alternating grants, r0 first
    submit(make_txn(0, 1'b1, 32'h0000_0020, 32'h1111_0000, 4'h3, 2'b01, 1, 32'h0, 1'b0));
    submit(make_txn(1, 1'b0, 32'h0000_0120, 32'h0, 4'h0, 2'b10, 2, 32'h0000_0011, 1'b0));
    submit(make_txn(0, 1'b0, 32'h0000_0024, 32'h0, 4'h0, 2'b01, 3, 32'h0000_0022, 1'b0));
    submit(make_txn(1, 1'b1, 32'h0000_0124, 32'h2222_0000, 4'hC, 2'b10, 1, 32'h0, 1'b0));
    wait_drain("drain_arb", 100);

    // illegal selects: immediate error, no bus activity
    submit(make_txn(0, 1'b1, 32'h0000_0030, 32'hDEAD_0000, 4'hF, 2'b11, 1, 32'h0, 1'b0));
    wait_drain("drain_sel11", 40);
    submit(make_txn(1, 1'b0, 32'h0000_0034, 32'h0, 4'h0, 2'b00, 1, 32'h0, 1'b0));
    wait_drain("drain_sel00", 40);

    // stalled slave: timeout after TMO WAIT cycles
    submit(make_txn(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 2'b01, 0, 32'hFFFF_FFFF, 1'b0));
    wait_drain("drain_tmo", 60);

    // slave error on a read: error flagged, data still returned
    submit(make_txn(1, 1'b0, 32'h0000_0144, 32'h0, 4'h0, 2'b10, 1, 32'h0000_A5A5, 1'b1));
    wait_drain("drain_slverr", 40);

    // r0 served last so a contended request would now favour r1
    submit(make_txn(0, 1'b0, 32'h0000_0048, 32'h0, 4'h0, 2'b01, 4, 32'hDEAD_BEEF, 1'b0));
    wait_drain("drain_rd2", 40);

    // reset in the middle of a WAIT: no response, everything back to zero
    rq1.push_back(make_txn(1, 1'b1, 32'h0000_0150, 32'h0BAD_0BAD, 4'hF, 2'b10, 0, 32'h0, 1'b0));
    n = 0;
    while (!TRANSFER_FLAG && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    check_eq("abort_flag_up", TRANSFER_FLAG, 1);
    repeat (3) @(negedge PCLK);
    #2;
    PRESETn = 0;
    @(negedge PCLK);
    check_eq("abort_rst_cmd", cmd_now, 0);
    check_eq("abort_rst_rsp", rsp_now, 0);
    #2;
    PRESETn = 1;
    repeat (2 * TMO + 4) @(negedge PCLK);
    check_eq("abort_no_flag", TRANSFER_FLAG, 0);
    #2;

    // after reset the pointer favours r0 again
    submit(make_txn(0, 1'b0, 32'h0000_0060, 32'h0, 4'h0, 2'b01, 1, 32'h0000_1234, 1'b0));
    submit(make_txn(1, 1'b1, 32'h0000_0160, 32'h7777_8888, 4'h5, 2'b10, 2, 32'h0, 1'b0));
    wait_drain("drain_post_rst", 60);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
